// File: rtl/decoder_proj_formal_dut.sv
// decoder_proj_formal_dut: multi-mode 4-bit code decoder with a registered result.
// A strobe (io_in[4]) samples code io_in[3:0] and mode io_in[6:5]. One cycle later
// the result appears on dec_o/seg_o/err_o together with a one-cycle valid_o pulse.
// Modes: 00 one-hot, 01 hex 7-seg, 10 BCD 7-seg (blank + err for 10..15),
// 11 thermometer. count_o counts accepted strobes and saturates at all-ones.
// Optional macro DECODER_PROJ_FORMAL_EN compiles in the embedded assume/assert/cover
// properties; without it the logic is identical and carries no property code.
module decoder_proj_formal_dut #(
  parameter int CNT_W = 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [6:0]       io_in,
  output logic [15:0]      dec_o,
  output logic [6:0]       seg_o,
  output logic             valid_o,
  output logic             err_o,
  output logic [CNT_W-1:0] count_o
);

  typedef enum logic [1:0] {
    MODE_ONEHOT = 2'b00,
    MODE_HEX    = 2'b01,
    MODE_BCD    = 2'b10,
    MODE_THERM  = 2'b11
  } mode_e;

  // Hex digit to 7-seg pattern {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex_seg(input logic [3:0] c);
    case (c)
      4'h0: return 7'h3F;
      4'h1: return 7'h06;
      4'h2: return 7'h5B;
      4'h3: return 7'h4F;
      4'h4: return 7'h66;
      4'h5: return 7'h6D;
      4'h6: return 7'h7D;
      4'h7: return 7'h07;
      4'h8: return 7'h7F;
      4'h9: return 7'h6F;
      4'hA: return 7'h77;
      4'hB: return 7'h7C;
      4'hC: return 7'h39;
      4'hD: return 7'h5E;
      4'hE: return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Bits [c:0] set; the 17-bit intermediate keeps code F from overflowing.
  function automatic logic [15:0] therm(input logic [3:0] c);
    logic [16:0] t;
    t = (17'h2 << c) - 17'd1;
    return t[15:0];
  endfunction

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [3:0]  code_p0;
  logic        en_p0;
  mode_e       mode_p0;
  logic [15:0] dec_p0;
  logic [6:0]  seg_p0;
  logic        err_p0;

  logic [15:0]      dec_p1;
  logic [6:0]       seg_p1;
  logic             err_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] count_p1;

  assign code_p0 = io_in[3:0];
  assign en_p0   = io_in[4];
  assign mode_p0 = mode_e'(io_in[6:5]);

  // Stage p0: decode the sampled code according to the mode.
  always_comb begin
    dec_p0 = '0;
    seg_p0 = '0;
    err_p0 = 1'b0;
    case (mode_p0)
      MODE_ONEHOT: dec_p0 = 16'h1 << code_p0;
      MODE_HEX:    seg_p0 = hex_seg(code_p0);
      MODE_BCD: begin
        if (code_p0 > 4'd9) err_p0 = 1'b1;
        else                seg_p0 = hex_seg(code_p0);
      end
      default:     dec_p0 = therm(code_p0);
    endcase
  end

  // Stage p1: register the result on a strobe; reset clears everything and wins.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dec_p1   <= '0;
      seg_p1   <= '0;
      err_p1   <= 1'b0;
      vld_p1   <= 1'b0;
      count_p1 <= '0;
    end else if (en_p0) begin
      dec_p1   <= dec_p0;
      seg_p1   <= seg_p0;
      err_p1   <= err_p0;
      vld_p1   <= 1'b1;
      count_p1 <= sat_inc(count_p1);
    end else begin
      vld_p1   <= 1'b0;
    end
  end

  assign dec_o   = dec_p1;
  assign seg_o   = seg_p1;
  assign err_o   = err_p1;
  assign valid_o = vld_p1;
  assign count_o = count_p1;

`ifdef DECODER_PROJ_FORMAL_EN
  logic             f_past;
  logic             f_rst_q;
  logic             f_en_q1;
  logic             f_en_q2;
  logic [1:0]       f_mode_q;
  logic             f_vld_q;
  logic [6:0]       f_io_q;
  logic [CNT_W-1:0] f_cnt_q;
  logic [16:0]      f_therm_inc;

  // History of the previous cycles for the temporal properties below.
  always_ff @(posedge wb_clk_i) begin
    f_past   <= 1'b1;
    f_rst_q  <= wb_rst_i;
    f_en_q1  <= en_p0;
    f_en_q2  <= f_en_q1;
    f_mode_q <= io_in[6:5];
    f_vld_q  <= valid_o;
    f_io_q   <= io_in;
    f_cnt_q  <= count_o;
  end

  assign f_therm_inc = {1'b0, dec_o} + 17'd1;

  // Embedded properties, evaluated on the current register state.
  always_comb begin
    if (!f_past) assume (wb_rst_i);
    if (f_past && valid_o && f_mode_q == MODE_ONEHOT) assert ($onehot(dec_o));
    if (f_past && valid_o && f_mode_q == MODE_THERM)
      assert ((f_therm_inc & (f_therm_inc - 17'd1)) == 17'd0);
    if (err_o) assert (seg_o == 7'd0);
    if (f_past && valid_o && f_vld_q) assert (f_en_q1 && f_en_q2);
    if (f_past && !f_rst_q) assert (count_o >= f_cnt_q);
    cover (f_past && valid_o && f_mode_q == MODE_THERM);
    cover (err_o);
    cover (&count_o);
    cover (f_past && !f_rst_q && f_io_q == 7'b1101110 && !valid_o);
  end
`endif

endmodule

// File: tb/tb_decoder_proj_formal_dut.sv
// Directed testbench for decoder_proj_formal_dut with immediate-assertion checks.
module tb_decoder_proj_formal_dut;

  localparam int CNT_W = 8;

  logic             clk;
  logic             rst;
  logic [6:0]       io;
  logic [15:0]      dec;
  logic [6:0]       seg;
  logic             vld;
  logic             err;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int fails  = 0;

  decoder_proj_formal_dut #(.CNT_W(CNT_W)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .io_in    (io),
    .dec_o    (dec),
    .seg_o    (seg),
    .valid_o  (vld),
    .err_o    (err),
    .count_o  (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Spec table of 7-seg patterns, codes 0..F.
  logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs set after this return are sampled at the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_dec, input logic [6:0] e_seg,
                         input logic e_vld, input logic e_err, input logic [CNT_W-1:0] e_cnt);
    chk({tag, ".dec"},   32'(dec), 32'(e_dec));
    chk({tag, ".seg"},   32'(seg), 32'(e_seg));
    chk({tag, ".valid"}, 32'(vld), 32'(e_vld));
    chk({tag, ".err"},   32'(err), 32'(e_err));
    chk({tag, ".count"}, 32'(cnt), 32'(e_cnt));
  endtask

  initial begin
    logic [15:0] e_dec;
    logic [6:0]  e_seg;
    logic        e_err;
    logic [3:0]  c;
    logic [1:0]  m;
    int          e_cnt;

    rst = 1'b1;
    io  = 7'd0;
    step();
    step();
    chk_all("reset", 16'h0, 7'h0, 1'b0, 1'b0, 8'd0);

    rst = 1'b0;
    io  = 7'b1101110;
    step();
    chk_all("no_strobe", 16'h0, 7'h0, 1'b0, 1'b0, 8'd0);

    io = 7'b0010101;
    step();
    chk_all("onehot5", 16'h0020, 7'h0, 1'b1, 1'b0, 8'd1);
    io = 7'b0000000;
    step();
    chk_all("hold", 16'h0020, 7'h0, 1'b0, 1'b0, 8'd1);

    io = 7'b0111010;
    step();
    chk_all("hexA", 16'h0, 7'h77, 1'b1, 1'b0, 8'd2);
    io = 7'b0110100;
    step();
    chk_all("hex4", 16'h0, 7'h66, 1'b1, 1'b0, 8'd3);

    io = 7'b1011100;
    step();
    chk_all("bcdC", 16'h0, 7'h00, 1'b1, 1'b1, 8'd4);
    io = 7'b1011001;
    step();
    chk_all("bcd9", 16'h0, 7'h6F, 1'b1, 1'b0, 8'd5);

    io = 7'b1110011;
    step();
    chk_all("therm3", 16'h000F, 7'h0, 1'b1, 1'b0, 8'd6);
    io = 7'b1111111;
    step();
    chk_all("thermF", 16'hFFFF, 7'h0, 1'b1, 1'b0, 8'd7);

    // 300 back-to-back strobes sweeping every mode and code; count must stick at 255.
    e_cnt = 7;
    for (int i = 0; i < 300; i++) begin
      c  = 4'(i);
      m  = 2'(i >> 4);
      io = {m, 1'b1, c};
      step();
      e_dec = 16'h0;
      e_seg = 7'h0;
      e_err = 1'b0;
      case (m)
        2'b00: e_dec[c] = 1'b1;
        2'b01: e_seg = hex_tab[c];
        2'b10: if (c >= 4'd10) e_err = 1'b1; else e_seg = hex_tab[c];
        default: for (int b = 0; b < 16; b++) if (b <= int'(c)) e_dec[b] = 1'b1;
      endcase
      if (e_cnt < 255) e_cnt++;
      chk_all($sformatf("sweep%0d", i), e_dec, e_seg, 1'b1, e_err, 8'(e_cnt));
    end
    chk("saturated", 32'(cnt), 32'd255);

    // Reset with a simultaneous strobe: reset wins.
    rst = 1'b1;
    io  = 7'b1111111;
    step();
    chk_all("midreset", 16'h0, 7'h0, 1'b0, 1'b0, 8'd0);
    rst = 1'b0;
    io  = 7'b0010000;
    step();
    chk_all("post_reset", 16'h0001, 7'h0, 1'b1, 1'b0, 8'd1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
